cam_capture_roi: RTL

- Parametrised successor to the camera capture path: samples OV7670 bytes on the pixel clock and assembles them into pixels in a selectable format.
- Crops each frame to a programmable window and decimates by powers of two.
- Buffers results in an internal first-word-fall-through FIFO with a valid/ready output, frame/line markers, overflow detection and a frame counter.
- Sits between the camera pins and the cam-side async FIFO / vp_top handshake.

---
 rtl/cam_pkg.sv | 38 +++
 rtl/sync_fifo_fwft.sv | 55 +++++
 rtl/cam_capture_roi.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path.
//   - capture mode encodings driven on i_mode
//   - capture FSM state type
//   - byte-pair to pixel assembly helper
package cam_pkg;

    localparam logic [1:0] MODE_RGB444 = 2'd0;
    localparam logic [1:0] MODE_RGB565 = 2'd1;
    localparam logic [1:0] MODE_Y      = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SYNC  = 2'd1,
        S_FRAME = 2'd2
    } state_t;

    // Builds a 16-bit pixel from the first (b0) and second (b1) camera byte.
    // wide=1 selects the native 16-bit RGB565 layout; otherwise RGB565 is
    // reduced to 4 bits per channel so it fits a 12-bit pixel.
    // The reserved mode value falls through to RGB444.
    function automatic logic [15:0] assemble_pix(input logic [1:0] mode,
                                                 input logic       wide,
                                                 input logic [7:0] b0,
                                                 input logic [7:0] b1);
        logic [15:0] pix;
        pix = {4'h0, b0[3:0], b1};
        case (mode)
            MODE_RGB565: begin
                if (wide) pix = {b0, b1};
                else      pix = {4'h0, b0[7:4], b0[2:0], b1[7], b1[4:1]};
            end
            MODE_Y:  pix = {8'h00, b0};
            default: ;
        endcase
        return pix;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, din    write request and data
//   pop          read request (ignored while empty)
//   dout         head entry, forced to 0 while empty
//   full, empty  status
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module sync_fifo_fwft #(
    parameter int DW = 14,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          pop_ok;
    logic          push_ok;

    // The extra pointer MSB separates full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Gating keeps the outputs at 0 whenever nothing is valid, including reset.
    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/cam_capture_roi.sv
// OV7670 capture with crop window, power-of-two decimation and FWFT output.
// Ports:
//   i_clk, i_rstn         pixel clock, asynchronous active-low reset
//   i_en                  capture enable
//   i_mode, i_dec         pixel format and decimation shift (latched per frame)
//   i_x0/i_x1/i_y0/i_y1   inclusive crop window (latched per frame)
//   i_clr_ovf             clears o_overflow
//   i_vsync, i_href, i_D  camera timing and data byte
//   i_ready               downstream ready
//   o_valid, o_data       FIFO head
//   o_sof, o_eol          head is first pixel of frame / last pixel of line
//   o_overflow            sticky drop indicator
//   o_frame_cnt           completed frame count
//
// state   | meaning
// S_IDLE  | capture disabled
// S_SYNC  | enabled, waiting for vsync fall (start of frame)
// S_FRAME | capturing bytes until vsync rises
module cam_capture_roi
    import cam_pkg::*;
#(
    parameter int PIX_W   = 12,
    parameter int CNT_W   = 10,
    parameter int FIFO_AW = 3,
    parameter int FCNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_en,
    input  logic [1:0]        i_mode,
    input  logic [1:0]        i_dec,
    input  logic [CNT_W-1:0]  i_x0,
    input  logic [CNT_W-1:0]  i_x1,
    input  logic [CNT_W-1:0]  i_y0,
    input  logic [CNT_W-1:0]  i_y1,
    input  logic              i_clr_ovf,
    input  logic              i_vsync,
    input  logic              i_href,
    input  logic [7:0]        i_D,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [PIX_W-1:0]  o_data,
    output logic              o_sof,
    output logic              o_eol,
    output logic              o_overflow,
    output logic [FCNT_W-1:0] o_frame_cnt
);

    state_t state, state_nxt;

    logic vs_q, hr_q;
    logic vs_fall, vs_rise, hr_fall;
    logic frame_start;
    logic capturing;

    logic [1:0]       cfg_mode;
    logic [1:0]       cfg_dec;
    logic [CNT_W-1:0] cfg_x0, cfg_x1, cfg_y0, cfg_y1;
    logic [CNT_W-1:0] x_last;
    logic [CNT_W-1:0] x_span;
    logic [CNT_W-1:0] x_last_d;

    logic             phase;
    logic [7:0]       b0, b1;
    logic [CNT_W-1:0] x, y;
    logic             pair_vld;
    logic [CNT_W-1:0] pair_x, pair_y;

    logic [CNT_W-1:0] dec_mask;
    logic [CNT_W-1:0] dx, dy;
    logic             keep;
    logic [15:0]      pix_full;
    logic [PIX_W-1:0] pix_next;

    logic             sof_pend;
    logic             pix_vld;
    logic [PIX_W-1:0] pix_data;
    logic             pix_sof, pix_eol;

    logic             fifo_full, fifo_empty;
    logic             pop;
    logic [PIX_W+1:0] fifo_dout;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign vs_fall     = vs_q & ~i_vsync;
    assign vs_rise     = ~vs_q & i_vsync;
    assign hr_fall     = hr_q & ~i_href;
    assign frame_start = (state == S_SYNC) && i_en && vs_fall;
    assign capturing   = (state == S_FRAME) && i_href;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= S_IDLE;
            vs_q  <= 1'b0;
            hr_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            vs_q  <= i_vsync;
            hr_q  <= i_href;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_en) state_nxt = S_SYNC;
            S_SYNC: begin
                if (!i_en)        state_nxt = S_IDLE;
                else if (vs_fall) state_nxt = S_FRAME;
            end
            S_FRAME: if (vs_rise) state_nxt = i_en ? S_SYNC : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Last column that survives decimation; this is where eol is flagged.
    assign x_span   = i_x1 - i_x0;
    assign x_last_d = i_x0 + ((x_span >> i_dec) << i_dec);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cfg_mode <= MODE_RGB444;
            cfg_dec  <= '0;
            cfg_x0   <= '0;
            cfg_x1   <= '0;
            cfg_y0   <= '0;
            cfg_y1   <= '0;
            x_last   <= '0;
        end else if (vs_fall) begin
            cfg_mode <= i_mode;
            cfg_dec  <= i_dec;
            cfg_x0   <= i_x0;
            cfg_x1   <= i_x1;
            cfg_y0   <= i_y0;
            cfg_y1   <= i_y1;
            x_last   <= x_last_d;
        end
    end

    // Byte pairing and position counters. The pixel position travels with the
    // byte pair so a following href fall cannot disturb it.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            phase    <= 1'b0;
            b0       <= '0;
            b1       <= '0;
            x        <= '0;
            y        <= '0;
            pair_vld <= 1'b0;
            pair_x   <= '0;
            pair_y   <= '0;
        end else begin
            pair_vld <= capturing & phase;
            if (capturing) begin
                phase <= ~phase;
                if (!phase) begin
                    b0 <= i_D;
                end else begin
                    b1     <= i_D;
                    pair_x <= x;
                    pair_y <= y;
                    x      <= sat_inc(x);
                end
            end else if (!i_href) begin
                phase <= 1'b0;
            end

            if (frame_start) begin
                x <= '0;
                y <= '0;
            end else if (hr_fall) begin
                x <= '0;
                if (state == S_FRAME) y <= sat_inc(y);
            end
        end
    end

    assign dec_mask = ~({CNT_W{1'b1}} << cfg_dec);
    assign dx       = pair_x - cfg_x0;
    assign dy       = pair_y - cfg_y0;
    assign keep     = (pair_x >= cfg_x0) && (pair_x <= cfg_x1) &&
                      (pair_y >= cfg_y0) && (pair_y <= cfg_y1) &&
                      ((dx & dec_mask) == '0) && ((dy & dec_mask) == '0);

    assign pix_full = assemble_pix(cfg_mode, (PIX_W == 16), b0, b1);

    if (PIX_W == 16) begin : g_pix16
        assign pix_next = pix_full;
    end else begin : g_pix12
        logic unused_pix_hi;
        assign pix_next      = pix_full[PIX_W-1:0];
        assign unused_pix_hi = ^pix_full[15:PIX_W];
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sof_pend <= 1'b0;
            pix_vld  <= 1'b0;
            pix_data <= '0;
            pix_sof  <= 1'b0;
            pix_eol  <= 1'b0;
        end else begin
            pix_vld <= pair_vld & keep;
            if (pair_vld && keep) begin
                pix_data <= pix_next;
                pix_sof  <= sof_pend;
                pix_eol  <= (pair_x == x_last);
            end
            if (frame_start)           sof_pend <= 1'b1;
            else if (pair_vld && keep) sof_pend <= 1'b0;
        end
    end

    assign pop = o_valid & i_ready;

    sync_fifo_fwft #(
        .DW (PIX_W + 2),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rstn),
        .push  (pix_vld),
        .din   ({pix_sof, pix_eol, pix_data}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign o_valid = ~fifo_empty;
    assign o_sof   = fifo_dout[PIX_W+1];
    assign o_eol   = fifo_dout[PIX_W];
    assign o_data  = fifo_dout[PIX_W-1:0];

    // Set wins over clear so a drop in the clearing cycle is not lost.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_overflow  <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            if (pix_vld && fifo_full && !pop) o_overflow <= 1'b1;
            else if (i_clr_ovf)               o_overflow <= 1'b0;
            if (state == S_FRAME && vs_rise)  o_frame_cnt <= o_frame_cnt + 1'b1;
        end
    end

endmodule
